// File: rtl/count_step_pkg.sv
// count_step_pkg
//   Shared types for the step generator: operating mode and the
//   button debouncer state encoding.
package count_step_pkg;

  typedef enum logic {
    MODE_STEP = 1'b0,
    MODE_AUTO = 1'b1
  } step_mode_e;

  typedef enum logic [1:0] {
    LO_STABLE = 2'd0,
    LO_WAIT   = 2'd1,
    HI_STABLE = 2'd2,
    HI_WAIT   = 2'd3
  } db_state_e;

  // Debounced level implied by a debouncer state.
  function automatic logic db_level(input db_state_e s);
    return (s == HI_STABLE) || (s == HI_WAIT);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Two-flop synchronizer followed by a four-state debouncer. A level
//   change is accepted after DEBOUNCE_CYCLES consecutive synchronized
//   samples at the new level.
//
//   Ports
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     btn_raw  in   raw button, asynchronous to clk
//     btn_db   out  registered debounced level
//     rise     out  high in the cycle before btn_db goes 0 -> 1
//
//   state     | meaning
//   ----------+------------------------------------------------
//   LO_STABLE | accepted level 0, input agrees
//   LO_WAIT   | accepted level 0, counting consecutive 1 samples
//   HI_STABLE | accepted level 1, input agrees
//   HI_WAIT   | accepted level 1, counting consecutive 0 samples
module btn_debounce
  import count_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_db,
  output logic rise
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_db_q, btn_db_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= LO_STABLE;
      cnt_q    <= '0;
      btn_db_q <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_db_q <= btn_db_d;
    end
  end

  // The first opposite sample already counts as one; with a threshold of
  // one it is accepted immediately. The counter never exceeds CNT_DONE,
  // so it cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LO_STABLE: begin
        if (sync2_q) begin
          if (CNT_ONE >= CNT_DONE) begin
            state_d = HI_STABLE;
            cnt_d   = '0;
          end else begin
            state_d = LO_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      LO_WAIT: begin
        if (!sync2_q) begin
          state_d = LO_STABLE;
          cnt_d   = '0;
        end else if (cnt_q + CNT_ONE >= CNT_DONE) begin
          state_d = HI_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HI_STABLE: begin
        if (!sync2_q) begin
          if (CNT_ONE >= CNT_DONE) begin
            state_d = LO_STABLE;
            cnt_d   = '0;
          end else begin
            state_d = HI_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      HI_WAIT: begin
        if (sync2_q) begin
          state_d = HI_STABLE;
          cnt_d   = '0;
        end else if (cnt_q + CNT_ONE >= CNT_DONE) begin
          state_d = LO_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LO_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // btn_db follows the next state so it changes on the accepting edge.
  assign btn_db_d = db_level(state_d);
  assign rise     = btn_db_d & ~btn_db_q;
  assign btn_db   = btn_db_q;

endmodule

// File: rtl/count_step_gen.sv
// count_step_gen
//   Generates a one-cycle enable strobe for a downstream counter, either
//   from debounced button presses (single-step) or from a programmable
//   free-running prescaler (auto-rate).
//
//   Ports
//     clk         in   system clock
//     rst_n       in   asynchronous active-low reset
//     btn_raw     in   raw button, asynchronous to clk
//     mode        in   0 = single-step, 1 = auto-rate
//     run         in   auto-rate enable
//     rate_div    in   auto period minus one, in clk cycles
//     btn_db      out  debounced button level
//     step_pulse  out  registered one-cycle step strobe
module count_step_gen
  import count_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_250_000,
  parameter int PRESCALE_W      = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_raw,
  input  logic                  mode,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] rate_div,
  output logic                  btn_db,
  output logic                  step_pulse
);

  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  step_mode_e            mode_in, mode_q;
  logic                  mode_chg;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  pulse_q, pulse_d;
  logic                  db_rise;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .btn_db  (btn_db),
    .rise    (db_rise)
  );

  assign mode_in  = step_mode_e'(mode);
  assign mode_chg = (mode_in != mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_STEP;
      pre_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      mode_q  <= mode_in;
      pre_q   <= pre_d;
      pulse_q <= pulse_d;
    end
  end

  // A mode change suppresses the strobe and parks the prescaler at 0.
  // Terminal count uses >= so lowering rate_div below the running count
  // still fires on the next edge instead of waiting for a wrap.
  always_comb begin
    pre_d   = '0;
    pulse_d = 1'b0;
    if (!mode_chg) begin
      if (mode_in == MODE_STEP) begin
        pulse_d = db_rise;
      end else if (run) begin
        if (pre_q >= rate_div) begin
          pulse_d = 1'b1;
        end else begin
          pre_d = pre_q + PRE_ONE;
        end
      end
    end
  end

  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_count_step_gen.sv
// tb_count_step_gen
//   Directed scenarios plus randomized stimulus, each cycle compared with
//   a behavioural model: the debounced level flips when the last
//   DEBOUNCE_CYCLES synchronized samples all disagree with it, and the
//   strobe follows the step/auto rules.
module tb_count_step_gen;

  localparam int DB = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          btn_raw = 1'b0;
  logic          mode = 1'b0;
  logic          run = 1'b0;
  logic [PW-1:0] rate_div = '0;
  logic          btn_db;
  logic          step_pulse;

  int checks = 0;
  int failures = 0;
  int pulses_seen = 0;
  int first;

  count_step_gen #(
    .DEBOUNCE_CYCLES(DB),
    .PRESCALE_W     (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .mode       (mode),
    .run        (run),
    .rate_div   (rate_div),
    .btn_db     (btn_db),
    .step_pulse (step_pulse)
  );

  always #4 clk = ~clk;

  // Raw samples, oldest first; entries [0..DB-1] are the samples the
  // debouncer sees after the two synchronizer stages.
  bit raw_hist[$];
  bit db_m;
  bit pulse_m;
  bit mode_prev_m;
  int pcnt_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_hist.delete();
    for (int i = 0; i < DB + 2; i++) raw_hist.push_back(1'b0);
    db_m        = 1'b0;
    pulse_m     = 1'b0;
    mode_prev_m = 1'b0;
    pcnt_m      = 0;
  endtask

  task automatic model_edge();
    bit all_opp;
    bit rose;
    bit mode_chg;
    raw_hist.push_back(btn_raw);
    void'(raw_hist.pop_front());
    all_opp = 1'b1;
    for (int i = 0; i < DB; i++) if (raw_hist[i] == db_m) all_opp = 1'b0;
    rose = all_opp && !db_m;
    if (all_opp) db_m = !db_m;
    mode_chg    = (mode != mode_prev_m);
    mode_prev_m = mode;
    pulse_m     = 1'b0;
    if (mode_chg || mode == 1'b0 || !run) begin
      pcnt_m = 0;
      if (!mode_chg && mode == 1'b0) pulse_m = rose;
    end else if (pcnt_m >= int'(rate_div)) begin
      pulse_m = 1'b1;
      pcnt_m  = 0;
    end else begin
      pcnt_m++;
    end
  endtask

  // One clock: model advances with the DUT, outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("btn_db", btn_db, db_m);
    check_eq("step_pulse", step_pulse, pulse_m);
    if (step_pulse) pulses_seen++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_btn_db", btn_db, 0);
    check_eq("rst_step_pulse", step_pulse, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit pat[10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

  initial begin
    model_reset();
    #2;
    do_reset();
    repeat (6) tick();

    // Scenario 1: clean press, then release
    btn_raw = 1'b1;
    pulses_seen = 0;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (first < 0 && btn_db) first = i;
    end
    check_eq("s1_rise_latency", first, 5);
    check_eq("s1_pulses", pulses_seen, 1);
    btn_raw = 1'b0;
    pulses_seen = 0;
    repeat (12) tick();
    check_eq("s1_release_db", btn_db, 0);
    check_eq("s1_release_pulses", pulses_seen, 0);

    // Scenario 2: bounce
    pulses_seen = 0;
    first = -1;
    for (int i = 0; i < 18; i++) begin
      btn_raw = (i < 10) ? pat[i] : 1'b1;
      tick();
      if (first < 0 && btn_db) first = i;
    end
    check_eq("s2_rise_index", first, 10);
    check_eq("s2_pulses", pulses_seen, 1);
    btn_raw = 1'b0;
    repeat (10) tick();

    // Scenario 3: auto rate 3, button activity ignored, then rate 0
    mode = 1'b1;
    run = 1'b0;
    rate_div = 8'd3;
    repeat (3) tick();
    run = 1'b1;
    btn_raw = 1'b1;
    pulses_seen = 0;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (first < 0 && step_pulse) first = i;
    end
    check_eq("s3_first_pulse", first, 3);
    check_eq("s3_pulses", pulses_seen, 5);
    check_eq("s3_btn_db_auto", btn_db, 1);
    rate_div = 8'd0;
    pulses_seen = 0;
    repeat (8) tick();
    check_eq("s3_rate0_pulses", pulses_seen, 8);

    // Scenario 4: rate lowered below the running count
    run = 1'b0;
    rate_div = 8'd9;
    repeat (2) tick();
    run = 1'b1;
    pulses_seen = 0;
    repeat (7) tick();
    check_eq("s4_no_early_pulse", pulses_seen, 0);
    rate_div = 8'd2;
    tick();
    check_eq("s4_lowered_pulse", step_pulse, 1);
    pulses_seen = 0;
    repeat (9) tick();
    check_eq("s4_after_pulses", pulses_seen, 3);

    // Scenario 5: reset mid-debounce, button held through release
    mode = 1'b0;
    run = 1'b0;
    btn_raw = 1'b0;
    repeat (8) tick();
    btn_raw = 1'b1;
    repeat (5) tick();
    do_reset();
    pulses_seen = 0;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (first < 0 && btn_db) first = i;
    end
    check_eq("s5_fresh_press", first, 5);
    check_eq("s5_fresh_pulses", pulses_seen, 1);
    // mid-prescale reset with btn_db high
    mode = 1'b1;
    run = 1'b1;
    rate_div = 8'd6;
    repeat (4) tick();
    check_eq("s5_db_before", btn_db, 1);
    do_reset();
    pulses_seen = 0;
    repeat (3) tick();
    check_eq("s5_post_pulses", pulses_seen, 0);

    // Scenario 6: mode toggles with run held
    rate_div = 8'd5;
    repeat (4) tick();
    mode = 1'b0;
    tick();
    check_eq("s6_toggle_to_step", step_pulse, 0);
    repeat (3) tick();
    mode = 1'b1;
    tick();
    check_eq("s6_toggle_to_auto", step_pulse, 0);
    first = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (first < 0 && step_pulse) first = i;
    end
    check_eq("s6_restart_first", first, 5);

    // Randomized phase
    for (int blk = 0; blk < 150; blk++) begin
      int len;
      len = $urandom_range(1, 8);
      btn_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) rate_div = PW'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) do_reset();
      for (int j = 0; j < len; j++) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_step_gen.md
COUNT_STEP_GEN -- requirements
Module: count_step_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_250_000, is the number of consecutive stable synchronized samples needed to accept a button level change (10 ms at 125 MHz).
REQ-003 Parameter PRESCALE_W, default 27, is the width of the auto-rate divider.
REQ-004 Port clk  input  1  system clock (125 MHz).
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port btn_raw  input  1  raw mechanical push-button, asynchronous to clk.
REQ-007 Port mode  input  1  0 = single-step from button, 1 = auto-rate.
REQ-008 Port run  input  1  auto-rate enable; ignored in single-step mode.
REQ-009 Port rate_div  input  PRESCALE_W  auto period minus one, in clk cycles.
REQ-010 Port btn_db  output  1  debounced button level.
REQ-011 Port step_pulse  output  1  one-cycle enable strobe for the downstream up/down counter enable.

Function
REQ-012 btn_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 The debouncer SHALL be a 4-state FSM: LO_STABLE, LO_WAIT, HI_STABLE, HI_WAIT.
REQ-014 In LO_STABLE, a synchronized 1 SHALL move the FSM to LO_WAIT and load the stability counter to 1.
REQ-015 In LO_WAIT, a 1 SHALL increment the counter, and reaching DEBOUNCE_CYCLES SHALL move the FSM to HI_STABLE; a 0 SHALL return it to LO_STABLE with the counter cleared.
REQ-016 HI_STABLE and HI_WAIT SHALL mirror REQ-014 and REQ-015 with the polarities swapped.
REQ-017 btn_db SHALL be registered, 1 in HI_STABLE and HI_WAIT and 0 otherwise.
REQ-018 Latency SHALL be exact: a clean btn_raw rise sampled at edge N gives btn_db = 1 after edge N+1+DEBOUNCE_CYCLES.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES SHALL NOT change btn_db.
REQ-020 The stability counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL NOT wrap.
REQ-021 In single-step mode, step_pulse SHALL be high for exactly the one cycle in which btn_db rises.
REQ-022 In single-step mode, a btn_db fall SHALL NOT produce a pulse.
REQ-023 In auto mode with run = 1, the prescaler SHALL count 0..rate_div, assert step_pulse for one cycle when count equals rate_div, and reload 0 on that same edge.
REQ-024 In auto mode, rate_div = 0 SHALL give step_pulse high every cycle.
REQ-025 If rate_div is lowered below the current count, the prescaler SHALL treat count >= rate_div as terminal: pulse next cycle, then reload 0.
REQ-026 In auto mode, run = 0 SHALL hold the prescaler at 0 with step_pulse = 0.
REQ-027 When run rises, the first pulse SHALL occur rate_div+1 cycles later.
REQ-028 Any change of mode SHALL clear the prescaler.
REQ-029 step_pulse SHALL be 0 in the cycle following a mode change, so no spurious pulse appears from stale state.
REQ-030 In auto mode, button activity SHALL still update btn_db but SHALL NOT produce step_pulse.
REQ-031 step_pulse SHALL be registered, with no combinational path from any input.

Reset
REQ-032 On rst_n = 0, all outputs and state SHALL reset asynchronously: synchronizer flops 0, FSM LO_STABLE, stability counter 0, prescaler 0, btn_db 0, step_pulse 0.
REQ-033 Reset asserted mid-debounce or mid-count SHALL abandon the operation with no pulse emitted.
REQ-034 Reset release SHALL be synchronous to clk; the first cycle after release behaves as if starting from LO_STABLE.
REQ-035 A button held high through reset release SHALL register as a fresh press after DEBOUNCE_CYCLES and SHALL emit one pulse in single-step mode.

Structure
REQ-036 Package count_step_pkg SHALL hold typedef step_mode_e (MODE_STEP = 1'b0, MODE_AUTO = 1'b1) and typedef db_state_e (the four FSM states).
REQ-037 The synchronizer plus FSM SHALL be a sub-module btn_debounce (ports clk, rst_n, btn_raw, btn_db, rise).
REQ-038 The prescaler and step_pulse selection SHALL live in count_step_gen.

Verification (DEBOUNCE_CYCLES = 4, PRESCALE_W = 8)
REQ-039 Scenario 1: mode = 0, clean press held for 20 cycles -> btn_db rises exactly 5 cycles after the first sample, and exactly one step_pulse occurs; the release gives no pulse.
REQ-040 Scenario 2: mode = 0, bounce pattern 1,0,1,1,0,1,1,1,1,1 -> btn_db rises once, after the final four 1s, with exactly one pulse.
REQ-041 Scenario 3: mode = 1, run = 1, rate_div = 3 for 20 cycles -> pulses every 4th cycle, first at cycle 4 after run rises; rate_div = 0 -> pulse every cycle.
REQ-042 Scenario 4: mode = 1, rate_div = 9, count at 7, then rate_div changed to 2 -> pulse on the next cycle, then every 3 cycles.
REQ-043 Scenario 5: rst_n pulsed low mid-debounce (count 3) and mid-prescale -> all outputs are 0 immediately, with no pulse after release until the full criteria are re-met.
REQ-044 Scenario 6: mode toggled 1 -> 0 -> 1 while run = 1 -> the prescaler restarts from 0, with no pulse in the cycle after each toggle.
